// File: rtl/ifu_prefetch_pkg.sv
// Shared constants for the prefetching fetch unit: NOP, major opcodes,
// FSM state encodings and immediate decode helpers for the static predictor.
package ifu_prefetch_pkg;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0]  OPC_JAL    = 7'b110_1111;

    localparam logic [1:0] FS_BOOT  = 2'd0;
    localparam logic [1:0] FS_FETCH = 2'd1;
    localparam logic [1:0] FS_FLUSH = 2'd2;

    // Immediates sign-extended to 64 bits; callers truncate to XLEN.
    function automatic logic [63:0] b_imm(input logic [31:0] i);
        return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [63:0] j_imm(input logic [31:0] i);
        return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// fetch_fifo: synchronous FIFO, async active-high reset, push/pop/clear.
// Ports: clk, rst, push, pop, clear, wdata -> rdata (head), count.
module fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push && !clear && (count_q != (AW+1)'(DEPTH));
        do_pop  = pop && !clear && (count_q != '0);
        rptr_d  = rptr_q + AW'(do_pop);
        wptr_d  = wptr_q + AW'(do_push);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (clear) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: PC owner, pipelined imem requests (<= DEPTH in flight),
// DEPTH-entry instruction queue to decode, redirect flush with stale-response
// discard. Ports: clk/rst, imem_req/addr/gnt/rvalid/rdata, redir_valid/pc,
// id_valid/ready/inst/pc/pred_taken. `define FETCH_BTFN_EN enables the
// backward-taken/forward-not-taken + JAL predictor at fetch time.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_pred_taken
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 33 + XLEN;

    logic [1:0]      fsm_q, fsm_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count;
    logic [CW:0]     occ;
    logic [EW-1:0]   head;
    logic            rsp, push, pop, gnt, redir, pred;
    logic [XLEN-1:0] pred_tgt, redir_tgt;

    // A response with nothing outstanding belongs to a pre-reset request.
    assign rsp = imem_rvalid && (inflight_q != '0);

`ifdef FETCH_BTFN_EN
    logic        hit;
    logic [63:0] imm;

    always_comb begin
        hit = 1'b0;
        imm = '0;
        if (imem_rdata[6:0] == OPC_BRANCH && imem_rdata[31]) begin
            hit = 1'b1;
            imm = b_imm(imem_rdata);
        end else if (imem_rdata[6:0] == OPC_JAL) begin
            hit = 1'b1;
            imm = j_imm(imem_rdata);
        end
        pred     = hit && (fsm_q == FS_FETCH) && rsp && !redir_valid;
        pred_tgt = rsp_pc_q + XLEN'(imm);
    end
`else
    assign pred     = 1'b0;
    assign pred_tgt = rsp_pc_q;
`endif

    always_comb begin
        redir          = redir_valid || pred;
        redir_tgt      = redir_valid ? redir_pc : pred_tgt;
        redir_tgt[1:0] = 2'b00;
        occ      = {1'b0, count} + {1'b0, inflight_q};
        imem_req = (fsm_q == FS_FETCH) && !redir
                   && (occ < (CW+1)'(DEPTH));
        gnt  = imem_req && imem_gnt;
        push = (fsm_q == FS_FETCH) && rsp && !redir_valid;
        pop  = id_valid && id_ready;
        inflight_d = inflight_q + CW'(gnt) - CW'(rsp);

        discard_d = discard_q;
        if (fsm_q == FS_FLUSH && rsp && discard_q != '0)
            discard_d = discard_q - CW'(1);
        if (redir)
            discard_d = inflight_d;

        pc_d = pc_q;
        if (redir)    pc_d = redir_tgt;
        else if (gnt) pc_d = pc_q + XLEN'(4);

        // PC of the oldest live in-flight request.
        rsp_pc_d = rsp_pc_q;
        if (redir)     rsp_pc_d = redir_tgt;
        else if (push) rsp_pc_d = rsp_pc_q + XLEN'(4);

        fsm_d = fsm_q;
        case (fsm_q)
            FS_BOOT:  fsm_d = FS_FETCH;
            FS_FETCH: if (redir && inflight_d != '0) fsm_d = FS_FLUSH;
            FS_FLUSH: begin
                if (redir)
                    fsm_d = (inflight_d != '0) ? FS_FLUSH : FS_FETCH;
                else if (discard_d == '0)
                    fsm_d = FS_FETCH;
            end
            default:  fsm_d = FS_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= FS_BOOT;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fsm_q      <= fsm_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // Internal predictions keep the queue: the predicting entry must reach decode.
    fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_q (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redir_valid),
        .wdata ({pred, rsp_pc_q, imem_rdata}),
        .rdata (head),
        .count (count)
    );

    assign imem_addr     = pc_q;
    assign id_valid      = (count != '0);
    assign id_inst       = id_valid ? head[31:0] : NOP;
    assign id_pc         = id_valid ? head[XLEN+31:32] : '0;
    assign id_pred_taken = id_valid && head[EW-1];

endmodule
